dram_rd_prefetch: RTL and testbench

//  Read-side front end between the lenet core and the dram model. Accepts a burst read

---
 rtl/dram_rd_prefetch_if.sv | 38 +++
 rtl/dram_rd_prefetch.sv | 182 ++++++++++++++++++
 tb/tb_dram_rd_prefetch.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_rd_prefetch_if.sv
// Command, dram read and output-stream signals of dram_rd_prefetch, plus a debug view of its FSM.
// valid/ready: a word or command moves on a rising edge with valid && ready; the sender holds it stable while valid && !ready.
interface dram_rd_prefetch_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int LEN_WIDTH  = 16
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic                  dram_en_rd;
    logic [ADDR_WIDTH-1:0] dram_addr_rd;
    logic                  dram_valid;
    logic [DATA_WIDTH-1:0] dram_data_rd;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  busy;
    logic                  done;
    logic                  err_unexp;
    logic [1:0]            dbg_state;

    // Block side.
    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, dram_valid, dram_data_rd, out_ready,
        output cmd_ready, dram_en_rd, dram_addr_rd, out_valid, out_data, out_last,
        output busy, done, err_unexp, dbg_state
    );

    // Core / dram side.
    modport master (
        output cmd_valid, cmd_addr, cmd_len, dram_valid, dram_data_rd, out_ready,
        input  cmd_ready, dram_en_rd, dram_addr_rd, out_valid, out_data, out_last,
        input  busy, done, err_unexp, dbg_state
    );
endinterface

// File: rtl/dram_rd_prefetch.sv
// Burst read front end: issues one-word dram reads under FIFO credit, buffers the returns
// and streams them to the core in issue order.
module dram_rd_prefetch #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int LEN_WIDTH  = 16,
    parameter int FIFO_DEPTH = 8
) (
    input logic               clk,
    input logic               rst,
    dram_rd_prefetch_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_addr_rd;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_issued;
    logic [LEN_WIDTH-1:0]  r_popped;
    logic [CW-1:0]         r_outstanding;
    logic [CW-1:0]         r_count;
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic                  r_en_rd;
    logic                  r_cmd_ready;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    logic w_cmd_acc;
    logic w_out_valid;
    logic w_pop;
    logic w_push;
    logic w_credit_ok;
    logic w_issue;
    logic w_out_last;
    logic w_last_pop;

    assign w_cmd_acc   = bus.cmd_valid & r_cmd_ready;
    assign w_out_valid = (r_count != '0);
    assign w_pop       = w_out_valid & bus.out_ready;
    // Returns with nothing outstanding are dropped, so every push has a reserved slot.
    assign w_push      = bus.dram_valid & (r_outstanding != '0);
    assign w_credit_ok = ({1'b0, r_count} + {1'b0, r_outstanding}) < DEPTH_C;
    assign w_issue     = (r_state == S_ISSUE) & (r_issued != r_len) & w_credit_ok;
    assign w_out_last  = w_out_valid & (r_popped == (r_len - LEN_WIDTH'(1)));
    assign w_last_pop  = w_pop & w_out_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_addr_rd   <= '0;
            r_len       <= '0;
            r_issued    <= '0;
            r_popped    <= '0;
            r_en_rd     <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_en_rd <= w_issue;
            r_done  <= 1'b0;
            if (w_issue) begin
                r_addr_rd <= r_base + ADDR_WIDTH'(r_issued);
                r_issued  <= r_issued + LEN_WIDTH'(1);
            end
            if (w_pop) begin
                r_popped <= r_popped + LEN_WIDTH'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_acc) begin
                        r_base      <= bus.cmd_addr;
                        r_len       <= bus.cmd_len;
                        r_issued    <= '0;
                        r_popped    <= '0;
                        r_cmd_ready <= 1'b0;
                        if (bus.cmd_len == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_ISSUE;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (r_issued == r_len) begin
                        if (w_last_pop) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_last_pop) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_cmd_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.dram_data_rd;
        end
    end

    // A strobe and a return in the same cycle leave outstanding unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_err         <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            case ({w_issue, w_push})
                2'b10:   r_outstanding <= r_outstanding + CW'(1);
                2'b01:   r_outstanding <= r_outstanding - CW'(1);
                default: r_outstanding <= r_outstanding;
            endcase
            if (bus.dram_valid && (r_outstanding == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.cmd_ready    = r_cmd_ready;
    assign bus.dram_en_rd   = r_en_rd;
    assign bus.dram_addr_rd = r_addr_rd;
    assign bus.out_valid    = w_out_valid;
    assign bus.out_data     = w_out_valid ? r_mem[r_rptr] : '0;
    assign bus.out_last     = w_out_last;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.err_unexp    = r_err;
    assign bus.dbg_state    = r_state;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        ({1'b0, r_count} + {1'b0, r_outstanding}) <= DEPTH_C);
    a_hold_stall: assert property (@(posedge clk) disable iff (rst)
        (bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable(bus.out_data)));
    a_done_pulse: assert property (@(posedge clk) disable iff (rst)
        bus.done |=> !bus.done);
endmodule

// File: tb/tb_dram_rd_prefetch.sv
// Bench for dram_rd_prefetch: dram model with programmable latency, stream scoreboard,
// table of bursts plus directed timing, backpressure and reset sequences.
module tb_dram_rd_prefetch;
    localparam int DW    = 32;
    localparam int AW    = 18;
    localparam int LW    = 16;
    localparam int DEPTH = 8;

    typedef struct {
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        int            lat;
        int            rdy;
        int            exp_words;
        int            exp_strobes;
        logic [AW-1:0] exp_last_addr;
    } vec_t;

    logic clk;
    logic rst;
    dram_rd_prefetch_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

    dram_rd_prefetch #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int lat = 1;
    int rdy_mode = 0;
    logic stray_req = 1'b0;
    logic          slot_v [16];
    logic [AW-1:0] slot_a [16];

    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] exp_addr_q[$];
    int n_strobes, n_words, n_done, n_valid_cyc, n_accept;
    int tot_strobes = 0, tot_pops = 0, mon_outst = 0;
    int accept_cyc, first_strobe_cyc, last_strobe_cyc, first_hs_cyc, last_hs_cyc, done_cyc;
    logic [AW-1:0] last_addr;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] dram_word(input logic [AW-1:0] a);
        return 32'hD00D_0000 ^ {14'h0, a} ^ {a[7:0], 24'h0};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        n_strobes = 0; n_words = 0; n_done = 0; n_valid_cyc = 0; n_accept = 0;
        last_addr = '0;
        accept_cyc = 0; first_strobe_cyc = 0; last_strobe_cyc = 0;
        first_hs_cyc = 0; last_hs_cyc = 0; done_cyc = 0;
    endtask

    task automatic start_burst(input logic [AW-1:0] a, input logic [LW-1:0] n);
        int guard;
        for (int i = 0; i < int'(n); i++) begin
            logic [AW-1:0] x;
            x = a + AW'(i);
            exp_addr_q.push_back(x);
            exp_q.push_back(dram_word(x));
        end
        tick();
        guard = 0;
        while (!bus.cmd_ready && guard < 200) begin
            tick();
            guard++;
        end
        check("cmd_ready_before_cmd", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_len   = n;
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
    endtask

    task automatic wait_done(input int budget);
        int guard;
        guard = 0;
        while (n_done == 0 && guard < budget) begin
            tick();
            guard++;
        end
        check("done_seen", (n_done >= 1), 1);
        repeat (4) tick();
        check("cmd_ready_after_done", bus.cmd_ready, 1);
        check("busy_after_done", bus.busy, 0);
    endtask

    // dram model and consumer: read issued in cycle t returns in cycle t+lat.
    initial begin
        for (int k = 0; k < 16; k++) begin
            slot_v[k] = 1'b0;
            slot_a[k] = '0;
        end
        bus.dram_valid   = 1'b0;
        bus.dram_data_rd = '0;
        bus.out_ready    = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.dram_en_rd && !rst) begin
                slot_v[(cyc + lat) % 16] = 1'b1;
                slot_a[(cyc + lat) % 16] = bus.dram_addr_rd;
            end
            bus.dram_valid   = slot_v[cyc % 16] | stray_req;
            bus.dram_data_rd = slot_v[cyc % 16] ? dram_word(slot_a[cyc % 16]) : '0;
            slot_v[cyc % 16] = 1'b0;
            stray_req = 1'b0;
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'b0;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor and scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.cmd_valid && bus.cmd_ready) begin
                n_accept++;
                accept_cyc = cyc;
            end
            if (bus.dram_en_rd) begin
                n_strobes++;
                tot_strobes++;
                if (n_strobes == 1) first_strobe_cyc = cyc;
                last_strobe_cyc = cyc;
                last_addr = bus.dram_addr_rd;
                if (exp_addr_q.size() == 0) begin
                    check("strobe_unexpected", bus.dram_addr_rd, 'x);
                end else begin
                    check("strobe_addr", bus.dram_addr_rd, exp_addr_q.pop_front());
                end
                check("inflight_le_depth", ((tot_strobes - tot_pops) <= DEPTH), 1);
            end
            if (bus.dram_valid && mon_outst > 0) mon_outst--;
            if (bus.dram_en_rd) mon_outst++;
            if (bus.out_valid) n_valid_cyc++;
            if (prev_stall) begin
                check("stall_valid_held", bus.out_valid, 1);
                check("stall_data_held", bus.out_data, prev_data);
            end
            if (bus.out_valid && bus.out_ready) begin
                n_words++;
                tot_pops++;
                if (n_words == 1) first_hs_cyc = cyc;
                last_hs_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("word_unexpected", bus.out_data, 'x);
                end else begin
                    check("out_last", bus.out_last, (exp_q.size() == 1));
                    check("out_data", bus.out_data, exp_q.pop_front());
                end
            end
            prev_stall = bus.out_valid & ~bus.out_ready;
            prev_data  = bus.out_data;
            if (bus.done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    vec_t vecs[6];

    initial begin
        vecs[0] = '{addr: 18'h00100, len: 16'd4,   lat: 1, rdy: 0, exp_words: 4,   exp_strobes: 4,   exp_last_addr: 18'h00103};
        vecs[1] = '{addr: 18'h3FFFE, len: 16'd4,   lat: 2, rdy: 0, exp_words: 4,   exp_strobes: 4,   exp_last_addr: 18'h00001};
        vecs[2] = '{addr: 18'h00ABC, len: 16'd0,   lat: 1, rdy: 0, exp_words: 0,   exp_strobes: 0,   exp_last_addr: 18'h00000};
        vecs[3] = '{addr: 18'h02000, len: 16'd100, lat: 3, rdy: 2, exp_words: 100, exp_strobes: 100, exp_last_addr: 18'h02063};
        vecs[4] = '{addr: 18'h3FFF0, len: 16'd30,  lat: 5, rdy: 2, exp_words: 30,  exp_strobes: 30,  exp_last_addr: 18'h0000D};
        vecs[5] = '{addr: 18'h01234, len: 16'd9,   lat: 8, rdy: 0, exp_words: 9,   exp_strobes: 9,   exp_last_addr: 18'h0123C};

        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        clear_mon();

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_en_rd", bus.dram_en_rd, 0);
        check("rst_addr_rd", bus.dram_addr_rd, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err_unexp, 0);
        check("rst_state", bus.dbg_state, 0);
        tick();
        rst = 1'b0;

        // Basic burst timing at latency 1 with a free-running consumer.
        @(negedge clk);
        lat = 1;
        rdy_mode = 0;
        clear_mon();
        start_burst(18'h00100, 16'd4);
        wait_done(200);
        check("t1_words", n_words, 4);
        check("t1_strobes", n_strobes, 4);
        check("t1_accept_to_strobe", first_strobe_cyc - accept_cyc, 2);
        check("t1_strobes_back_to_back", last_strobe_cyc - first_strobe_cyc, 3);
        check("t1_strobe_to_word", first_hs_cyc - first_strobe_cyc, 2);
        check("t1_last_strobe_to_word", last_hs_cyc - last_strobe_cyc, 2);
        check("t1_last_to_done", done_cyc - last_hs_cyc, 1);
        check("t1_done_count", n_done, 1);

        // Burst table.
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            lat = vecs[v].lat;
            rdy_mode = vecs[v].rdy;
            clear_mon();
            start_burst(vecs[v].addr, vecs[v].len);
            wait_done(3000);
            check($sformatf("v%0d_words", v), n_words, vecs[v].exp_words);
            check($sformatf("v%0d_strobes", v), n_strobes, vecs[v].exp_strobes);
            check($sformatf("v%0d_done_count", v), n_done, 1);
            check($sformatf("v%0d_last_addr", v), last_addr, vecs[v].exp_last_addr);
            check($sformatf("v%0d_exp_q_empty", v), exp_q.size(), 0);
            check($sformatf("v%0d_err", v), bus.err_unexp, 0);
        end

        // Backpressure: credit limits issue to the FIFO depth; commands ignored while busy.
        @(negedge clk);
        lat = 1;
        rdy_mode = 1;
        clear_mon();
        start_burst(18'h00500, 16'd20);
        repeat (50) tick();
        check("bp_strobes_capped", n_strobes, DEPTH);
        check("bp_en_rd_low", bus.dram_en_rd, 0);
        check("bp_out_valid", bus.out_valid, 1);
        check("bp_head_data", bus.out_data, exp_q[0]);
        check("bp_busy", bus.busy, 1);
        check("bp_state_issue", bus.dbg_state, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 18'h00999;
        bus.cmd_len   = 16'd3;
        tick();
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        @(negedge clk);
        rdy_mode = 0;
        wait_done(1000);
        check("bp_words", n_words, 20);
        check("bp_strobes", n_strobes, 20);
        check("bp_accepts", n_accept, 1);
        check("bp_exp_q_empty", exp_q.size(), 0);
        check("bp_err", bus.err_unexp, 0);

        // Zero-length command.
        @(negedge clk);
        clear_mon();
        start_burst(18'h00123, 16'd0);
        wait_done(100);
        check("z_accept_to_done", done_cyc - accept_cyc, 1);
        check("z_strobes", n_strobes, 0);
        check("z_valid_cycles", n_valid_cyc, 0);
        check("z_done_count", n_done, 1);

        // Reset mid-burst with the FIFO holding words and no read in flight.
        @(negedge clk);
        lat = 2;
        rdy_mode = 0;
        clear_mon();
        start_burst(18'h00040, 16'd16);
        begin
            int guard;
            guard = 0;
            while (n_words < 5 && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            rdy_mode = 1;
        end
        check("r_reach_word5", (n_words >= 5), 1);
        repeat (20) tick();
        check("r_no_inflight", mon_outst, 0);
        rst = 1'b1;
        @(negedge clk);
        check("r_cmd_ready", bus.cmd_ready, 1);
        check("r_en_rd", bus.dram_en_rd, 0);
        check("r_addr_rd", bus.dram_addr_rd, 0);
        check("r_out_valid", bus.out_valid, 0);
        check("r_out_data", bus.out_data, 0);
        check("r_out_last", bus.out_last, 0);
        check("r_busy", bus.busy, 0);
        check("r_done", bus.done, 0);
        check("r_err", bus.err_unexp, 0);
        check("r_state", bus.dbg_state, 0);
        exp_q.delete();
        exp_addr_q.delete();
        tot_strobes = 0;
        tot_pops = 0;
        mon_outst = 0;
        rdy_mode = 0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        clear_mon();
        start_burst(18'h3FFFF, 16'd2);
        wait_done(200);
        check("r2_words", n_words, 2);
        check("r2_strobes", n_strobes, 2);
        check("r2_last_addr", last_addr, 18'h00000);
        check("r2_err_clear", bus.err_unexp, 0);

        // Stray return with nothing outstanding.
        @(negedge clk);
        stray_req = 1'b1;
        repeat (3) tick();
        check("stray_err_set", bus.err_unexp, 1);
        check("stray_dropped", bus.out_valid, 0);
        repeat (5) tick();
        check("stray_err_sticky", bus.err_unexp, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
